// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - handshake/control bundle between the MIPS datapath and pipe_ctrl
//
// Signals grouped by direction as seen from the controller (slave modport):
//   inputs : step_mode, step, id_rs, id_rt, id_uses_rs, id_uses_rt, id_syscall,
//            ex_dst, ex_mem_read, jb_taken, halt_req, cnt_clr
//   outputs: pc_en, buf_en, buf_clr, stage_valid, lu, halted,
//            cyc_cnt, ret_cnt, lu_cnt, jb_cnt
// The master modport is the datapath side that drives the hazard information.
interface pipe_ctrl_if #(
    parameter int STAGES = 5,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
);
    logic              step_mode;
    logic              step;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_syscall;
    logic [REG_W-1:0]  ex_dst;
    logic              ex_mem_read;
    logic              jb_taken;
    logic              halt_req;
    logic              cnt_clr;

    logic              pc_en;
    logic [STAGES-2:0] buf_en;
    logic [STAGES-2:0] buf_clr;
    logic [STAGES-1:0] stage_valid;
    logic              lu;
    logic              halted;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [CNT_W-1:0]  lu_cnt;
    logic [CNT_W-1:0]  jb_cnt;

    modport master (
        output step_mode, step, id_rs, id_rt, id_uses_rs, id_uses_rt, id_syscall,
               ex_dst, ex_mem_read, jb_taken, halt_req, cnt_clr,
        input  pc_en, buf_en, buf_clr, stage_valid, lu, halted,
               cyc_cnt, ret_cnt, lu_cnt, jb_cnt
    );

    modport slave (
        input  step_mode, step, id_rs, id_rt, id_uses_rs, id_uses_rt, id_syscall,
               ex_dst, ex_mem_read, jb_taken, halt_req, cnt_clr,
        output pc_en, buf_en, buf_clr, stage_valid, lu, halted,
               cyc_cnt, ret_cnt, lu_cnt, jb_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller: stalls, flushes, halt, single-step, perf counters
//
// Ports:
//   clk   - core clock
//   rst_n - asynchronous active-low reset
//   bus   - pipe_ctrl_if.slave: hazard inputs in, buffer enables/clears, valid bits,
//           halt flag and performance counters out
// Stage 0 = IF, 1 = ID, 2 = EX; buffer k sits between stage k and k+1.
module pipe_ctrl #(
    parameter int STAGES   = 5,
    parameter int BR_STAGE = 2,
    parameter int REG_W    = 5,
    parameter int CNT_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_ctrl_if.slave    bus
);
    logic              r_step_q;
    logic              r_halted;
    logic [STAGES-1:0] r_valid;
    logic [CNT_W-1:0]  r_cyc_cnt;
    logic [CNT_W-1:0]  r_ret_cnt;
    logic [CNT_W-1:0]  r_lu_cnt;
    logic [CNT_W-1:0]  r_jb_cnt;

    logic              w_adv;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic              w_sys_hit;
    logic              w_hz;
    logic              w_fl;
    logic              w_lu;
    logic [STAGES-2:0] w_buf_en;
    logic [STAGES-2:0] w_buf_clr;
    logic [STAGES-1:0] w_valid_nxt;
    logic              w_halt_set;

    // Rising-edge detect on step so a long pulse still yields one advance.
    assign w_adv = ~r_halted & (~bus.step_mode | (bus.step & ~r_step_q));

    assign w_rs_hit  = bus.id_uses_rs & (bus.id_rs == bus.ex_dst);
    assign w_rt_hit  = bus.id_uses_rt & (bus.id_rt == bus.ex_dst);
    // A syscall implicitly reads $v0 ($2) and $a0 ($4).
    assign w_sys_hit = bus.id_syscall &
                       ((bus.ex_dst == REG_W'(2)) | (bus.ex_dst == REG_W'(4)));
    assign w_hz = r_valid[1] & r_valid[2] & bus.ex_mem_read &
                  (bus.ex_dst != '0) & (w_rs_hit | w_rt_hit | w_sys_hit);

    // A taken branch kills the younger instructions, including the stalled one,
    // so the flush wins over the interlock.
    assign w_fl = bus.jb_taken & r_valid[BR_STAGE];
    assign w_lu = w_hz & ~w_fl;

    always_comb begin
        w_buf_en  = '0;
        w_buf_clr = '0;
        for (int k = 0; k < STAGES - 1; k++) begin
            w_buf_en[k]  = w_adv;
            w_buf_clr[k] = w_adv & ((w_fl & (k < BR_STAGE)) | (w_lu & (k == 1)));
        end
        // On an interlock IF/ID holds while a bubble is pushed into EX.
        w_buf_en[0] = w_adv & ~w_lu;
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_adv) begin
            w_valid_nxt[0] = 1'b1;
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_buf_clr[k])
                    w_valid_nxt[k+1] = 1'b0;
                else if (w_buf_en[k])
                    w_valid_nxt[k+1] = r_valid[k];
            end
        end
    end

    assign w_halt_set = bus.halt_req & r_valid[STAGES-1] & w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_q <= 1'b0;
            r_halted <= 1'b0;
            r_valid  <= '0;
        end else begin
            r_step_q <= bus.step;
            r_valid  <= w_valid_nxt;
            if (w_halt_set)
                r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
            r_lu_cnt  <= '0;
            r_jb_cnt  <= '0;
        end else if (bus.cnt_clr) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
            r_lu_cnt  <= '0;
            r_jb_cnt  <= '0;
        end else if (w_adv) begin
            r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
            r_ret_cnt <= r_ret_cnt + CNT_W'(r_valid[STAGES-1]);
            r_lu_cnt  <= r_lu_cnt + CNT_W'(w_lu);
            r_jb_cnt  <= r_jb_cnt + CNT_W'(w_fl);
        end
    end

    assign bus.pc_en       = w_adv & ~w_lu;
    assign bus.buf_en      = w_buf_en;
    assign bus.buf_clr     = w_buf_clr;
    assign bus.stage_valid = r_valid;
    assign bus.lu          = w_lu;
    assign bus.halted      = r_halted;
    assign bus.cyc_cnt     = r_cyc_cnt;
    assign bus.ret_cnt     = r_ret_cnt;
    assign bus.lu_cnt      = r_lu_cnt;
    assign bus.jb_cnt      = r_jb_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.STAGES(5), .REG_W(5), .CNT_W(32)) bus ();

    pipe_ctrl #(.STAGES(5), .BR_STAGE(2), .REG_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazard();
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_uses_rs  = 1'b0;
        bus.id_uses_rt  = 1'b0;
        bus.id_syscall  = 1'b0;
        bus.ex_dst      = '0;
        bus.ex_mem_read = 1'b0;
        bus.jb_taken    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.step_mode = 1'b0;
        bus.step      = 1'b0;
        bus.halt_req  = 1'b0;
        bus.cnt_clr   = 1'b0;
        clear_hazard();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",  bus.stage_valid, 5'b00000);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_cyc",    bus.cyc_cnt, 32'd0);
        chk("rst_ret",    bus.ret_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("run_pc_en",   bus.pc_en, 1'b1);
        chk("run_buf_en",  bus.buf_en, 4'b1111);
        chk("run_buf_clr", bus.buf_clr, 4'b0000);

        // Straight-line fill
        tick(); chk("fill1", bus.stage_valid, 5'b00001);
        tick(); chk("fill2", bus.stage_valid, 5'b00011);
        tick(); chk("fill3", bus.stage_valid, 5'b00111);
        tick(); chk("fill4", bus.stage_valid, 5'b01111);
        tick(); chk("fill5", bus.stage_valid, 5'b11111);
        repeat (5) tick();
        chk("fill_cyc", bus.cyc_cnt, 32'd10);
        chk("fill_ret", bus.ret_cnt, 32'd5);

        // Clear counters while running: clear beats the increment
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("clr_cyc", bus.cyc_cnt, 32'd0);
        chk("clr_ret", bus.ret_cnt, 32'd0);

        // Load-use on rs
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
        #1;
        chk("lu_lu",      bus.lu, 1'b1);
        chk("lu_buf_en",  bus.buf_en, 4'b1110);
        chk("lu_buf_clr", bus.buf_clr, 4'b0010);
        chk("lu_pc_en",   bus.pc_en, 1'b0);
        tick();
        clear_hazard();
        chk("lu_bubble", bus.stage_valid, 5'b11011);
        chk("lu_cnt1",   bus.lu_cnt, 32'd1);
        chk("lu_cyc1",   bus.cyc_cnt, 32'd1);
        tick();
        chk("lu_after", bus.stage_valid, 5'b10111);

        // Hazard qualifiers (combinational only)
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1'b1;
        #1; chk("lu_dst0", bus.lu, 1'b0);
        bus.ex_dst = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b0;
        #1; chk("lu_nouse", bus.lu, 1'b0);
        bus.id_uses_rt = 1'b1; bus.id_rt = 5'd8;
        #1; chk("lu_rt", bus.lu, 1'b1);
        bus.id_uses_rt = 1'b1; bus.id_rt = 5'd8; bus.ex_mem_read = 1'b0;
        #1; chk("lu_noload", bus.lu, 1'b0);
        clear_hazard();
        bus.ex_mem_read = 1'b1; bus.id_syscall = 1'b1; bus.ex_dst = 5'd2; bus.id_rs = 5'd9;
        #1; chk("lu_sys2", bus.lu, 1'b1);
        bus.ex_dst = 5'd4;
        #1; chk("lu_sys4", bus.lu, 1'b1);
        bus.ex_dst = 5'd3;
        #1; chk("lu_sys3", bus.lu, 1'b0);
        clear_hazard();

        // Clear counters (pipeline advances 10111 -> 01111)
        bus.cnt_clr = 1'b1;
        tick();
        bus.cnt_clr = 1'b0;
        chk("pre_fl_valid", bus.stage_valid, 5'b01111);

        // Flush with a simultaneous hazard
        bus.ex_mem_read = 1'b1; bus.ex_dst = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1'b1;
        bus.jb_taken = 1'b1;
        #1;
        chk("fl_buf_clr", bus.buf_clr, 4'b0011);
        chk("fl_lu",      bus.lu, 1'b0);
        chk("fl_pc_en",   bus.pc_en, 1'b1);
        chk("fl_buf_en",  bus.buf_en, 4'b1111);
        tick();
        clear_hazard();
        chk("fl_valid",  bus.stage_valid, 5'b11001);
        chk("fl_jb_cnt", bus.jb_cnt, 32'd1);
        chk("fl_lu_cnt", bus.lu_cnt, 32'd0);
        chk("fl_cyc",    bus.cyc_cnt, 32'd1);

        // Single step: clear still works while stepping is idle
        bus.step_mode = 1'b1;
        bus.cnt_clr   = 1'b1;
        #1;
        chk("st_idle_pc", bus.pc_en, 1'b0);
        chk("st_idle_en", bus.buf_en, 4'b0000);
        tick();
        bus.cnt_clr = 1'b0;
        chk("st_hold_valid", bus.stage_valid, 5'b11001);
        chk("st_clr_cyc",    bus.cyc_cnt, 32'd0);
        bus.step = 1'b1;
        #1;
        chk("st_pc_first", bus.pc_en, 1'b1);
        tick();
        chk("st_pc_held", bus.pc_en, 1'b0);
        repeat (3) tick();
        bus.step = 1'b0;
        tick();
        chk("st_cyc",   bus.cyc_cnt, 32'd1);
        chk("st_ret",   bus.ret_cnt, 32'd1);
        chk("st_valid", bus.stage_valid, 5'b10011);

        // Halt together with counter clear
        bus.step_mode = 1'b0;
        bus.halt_req  = 1'b1;
        bus.cnt_clr   = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        bus.cnt_clr  = 1'b0;
        chk("h_halted",  bus.halted, 1'b1);
        chk("h_cyc",     bus.cyc_cnt, 32'd0);
        chk("h_valid",   bus.stage_valid, 5'b00111);
        chk("h_pc_en",   bus.pc_en, 1'b0);
        chk("h_buf_en",  bus.buf_en, 4'b0000);
        chk("h_buf_clr", bus.buf_clr, 4'b0000);
        bus.jb_taken = 1'b1;
        repeat (3) tick();
        bus.jb_taken = 1'b0;
        chk("h_frz_cyc",   bus.cyc_cnt, 32'd0);
        chk("h_frz_jb",    bus.jb_cnt, 32'd0);
        chk("h_frz_valid", bus.stage_valid, 5'b00111);
        chk("h_sticky",    bus.halted, 1'b1);

        // Asynchronous reset mid-halt
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_halted", bus.halted, 1'b0);
        chk("ar_valid",  bus.stage_valid, 5'b00000);
        chk("ar_pc_en",  bus.pc_en, 1'b1);
        chk("ar_buf_en", bus.buf_en, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_restart", bus.stage_valid, 5'b00001);
        chk("ar_cyc",     bus.cyc_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
